// File: rtl/sp_frame_unit.sv
// rtl/sp_frame_unit.sv - stack-pointer unit for a full-descending stack with push/pop and call/ret frames
module sp_frame_unit #(
  parameter int unsigned W        = 16,
  parameter int unsigned STEP     = 1,
  parameter int unsigned FRAME    = 2,
  parameter logic [W-1:0] SP_TOP   = 16'hFFFF,
  parameter logic [W-1:0] SP_LIMIT = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         call,
  input  logic         ret,
  input  logic         err_clr,
  output logic [W-1:0] sp,
  output logic [W-1:0] mem_addr,
  output logic         mem_we,
  output logic         mem_re,
  output logic         busy,
  output logic         empty,
  output logic         full,
  output logic         overflow,
  output logic         underflow
);

  localparam int unsigned CW = (FRAME > 1) ? $clog2(FRAME) : 1;

  // Bounds are evaluated one bit wider than SP so no sum or difference can wrap.
  localparam logic [W:0]    STEP_X   = (W+1)'(STEP);
  localparam logic [W:0]    FSTEP_X  = (W+1)'(FRAME * STEP);
  localparam logic [W:0]    TOP_X    = {1'b0, SP_TOP};
  localparam logic [W:0]    LIMIT_X  = {1'b0, SP_LIMIT};
  localparam logic [W-1:0]  STEP_W   = W'(STEP);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALL = 2'd1,
    S_RET  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sp_q, sp_d;
  logic [W-1:0]  addr_q, addr_d;
  logic          we_q, we_d;
  logic          re_q, re_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic [W:0] sp_x;
  logic       push_ok, pop_ok, call_ok, ret_ok;
  logic       set_ovf, set_unf;

  assign sp_x    = {1'b0, sp_q};
  assign push_ok = sp_x >= LIMIT_X + STEP_X;
  assign pop_ok  = sp_x + STEP_X <= TOP_X;
  assign call_ok = sp_x >= LIMIT_X + FSTEP_X;
  assign ret_ok  = sp_x + FSTEP_X <= TOP_X;

  // Command decode, frame sequencing and bounds checking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (call) begin
          if (call_ok) begin
            state_d = S_CALL;
            cnt_d   = '0;
            sp_d    = sp_q - STEP_W;
            addr_d  = sp_q - STEP_W;
            we_d    = 1'b1;
          end else begin
            set_ovf = 1'b1;
          end
        end else if (ret) begin
          if (ret_ok) begin
            state_d = S_RET;
            cnt_d   = '0;
            sp_d    = sp_q + STEP_W;
            addr_d  = sp_q;
            re_d    = 1'b1;
          end else begin
            set_unf = 1'b1;
          end
        end else if (push && pop) begin
          // Simultaneous push and pop cancel out: nothing moves, no flags.
        end else if (push) begin
          if (push_ok) begin
            sp_d   = sp_q - STEP_W;
            addr_d = sp_q - STEP_W;
            we_d   = 1'b1;
          end else begin
            set_ovf = 1'b1;
          end
        end else if (pop) begin
          if (pop_ok) begin
            sp_d   = sp_q + STEP_W;
            addr_d = sp_q;
            re_d   = 1'b1;
          end else begin
            set_unf = 1'b1;
          end
        end
      end
      S_CALL: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_IDLE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          sp_d   = sp_q - STEP_W;
          addr_d = sp_q - STEP_W;
          we_d   = 1'b1;
        end
      end
      S_RET: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_IDLE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          sp_d   = sp_q + STEP_W;
          addr_d = sp_q;
          re_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new error wins over a coincident clear.
    ovf_d = (ovf_q & ~err_clr) | set_ovf;
    unf_d = (unf_q & ~err_clr) | set_unf;
  end

  // State and output registers; reset overrides everything, including an in-flight frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sp_q    <= SP_TOP;
      addr_q  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      re_q    <= re_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign sp        = sp_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign busy      = (state_q != S_IDLE);
  assign empty     = (sp_q == SP_TOP);
  assign full      = sp_x < LIMIT_X + STEP_X;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_sp_frame_unit.sv
// tb/tb_sp_frame_unit.sv - directed self-checking bench for sp_frame_unit
module tb_sp_frame_unit;

  logic        clk = 1'b0;
  logic        rst_n, push, pop, call, ret, err_clr;
  logic [15:0] sp, mem_addr;
  logic        mem_we, mem_re, busy, empty, full, overflow, underflow;

  int n_checks = 0;
  int n_pass   = 0;

  sp_frame_unit #(
    .W(16), .STEP(2), .FRAME(3), .SP_TOP(16'h0100), .SP_LIMIT(16'h00F0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .call(call), .ret(ret),
    .err_clr(err_clr), .sp(sp), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_re(mem_re), .busy(busy), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; call = 1'b0; ret = 1'b0; err_clr = 1'b0;
    tick(); tick();
    check("rst_sp", sp, 32'h0100);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    rst_n = 1'b1;
    tick();

    // single push then pop
    push = 1'b1; tick(); push = 1'b0;
    check("push_sp", sp, 32'h00FE);
    check("push_addr", mem_addr, 32'h00FE);
    check("push_we", mem_we, 1);
    check("push_empty", empty, 0);
    tick();
    check("push_we_drop", mem_we, 0);
    pop = 1'b1; tick(); pop = 1'b0;
    check("pop_addr", mem_addr, 32'h00FE);
    check("pop_re", mem_re, 1);
    check("pop_sp", sp, 32'h0100);
    check("pop_empty", empty, 1);
    tick();
    check("pop_re_drop", mem_re, 0);

    // call with push held throughout
    call = 1'b1; tick(); call = 1'b0; push = 1'b1;
    check("call1_busy", busy, 1);
    check("call1_addr", mem_addr, 32'h00FE);
    check("call1_we", mem_we, 1);
    tick();
    check("call2_busy", busy, 1);
    check("call2_addr", mem_addr, 32'h00FC);
    check("call2_we", mem_we, 1);
    tick();
    check("call3_busy", busy, 1);
    check("call3_addr", mem_addr, 32'h00FA);
    check("call3_we", mem_we, 1);
    tick(); push = 1'b0;
    check("call_end_busy", busy, 0);
    check("call_end_we", mem_we, 0);
    check("call_end_sp", sp, 32'h00FA);
    tick();
    check("call_push_ignored", sp, 32'h00FA);

    // ret
    ret = 1'b1; tick(); ret = 1'b0;
    check("ret1_addr", mem_addr, 32'h00FA);
    check("ret1_re", mem_re, 1);
    check("ret1_busy", busy, 1);
    tick();
    check("ret2_addr", mem_addr, 32'h00FC);
    check("ret2_re", mem_re, 1);
    tick();
    check("ret3_addr", mem_addr, 32'h00FE);
    check("ret3_re", mem_re, 1);
    check("ret3_we", mem_we, 0);
    tick();
    check("ret_end_busy", busy, 0);
    check("ret_end_re", mem_re, 0);
    check("ret_end_sp", sp, 32'h0100);

    // fill to the limit
    push = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("fill_sp", sp, 32'h00F0);
    check("fill_addr", mem_addr, 32'h00F0);
    check("fill_full", full, 1);
    check("fill_ovf", overflow, 0);
    tick(); push = 1'b0;
    check("ovf_sp", sp, 32'h00F0);
    check("ovf_flag", overflow, 1);
    check("ovf_no_we", mem_we, 0);

    pop = 1'b1; tick(); tick(); pop = 1'b0;
    check("pop2_sp", sp, 32'h00F4);
    check("pop2_full", full, 0);
    call = 1'b1; tick(); call = 1'b0;
    check("call_ref_sp", sp, 32'h00F4);
    check("call_ref_busy", busy, 0);
    check("call_ref_we", mem_we, 0);
    check("call_ref_ovf", overflow, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_sp", sp, 32'h00F4);

    // drain and underflow
    pop = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("drain_sp", sp, 32'h0100);
    check("drain_unf", underflow, 0);
    tick(); pop = 1'b0;
    check("unf_flag", underflow, 1);
    check("unf_sp", sp, 32'h0100);
    check("unf_no_re", mem_re, 0);
    pop = 1'b1; err_clr = 1'b1; tick(); pop = 1'b0; err_clr = 1'b0;
    check("unf_set_wins", underflow, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("unf_clr", underflow, 0);

    // simultaneous push+pop, then shallow ret
    push = 1'b1; tick(); tick(); push = 1'b0;
    check("fc_sp", sp, 32'h00FC);
    push = 1'b1; pop = 1'b1; tick(); push = 1'b0; pop = 1'b0;
    check("pp_sp", sp, 32'h00FC);
    check("pp_we", mem_we, 0);
    check("pp_re", mem_re, 0);
    check("pp_ovf", overflow, 0);
    check("pp_unf", underflow, 0);
    ret = 1'b1; tick(); ret = 1'b0;
    check("ret_ref_unf", underflow, 1);
    check("ret_ref_sp", sp, 32'h00FC);
    check("ret_ref_busy", busy, 0);
    check("ret_ref_re", mem_re, 0);

    // reset in the middle of a call
    pop = 1'b1; tick(); tick(); pop = 1'b0;
    check("mid_start_sp", sp, 32'h0100);
    call = 1'b1; tick(); call = 1'b0;
    tick();
    check("mid_w2_addr", mem_addr, 32'h00FC);
    check("mid_w2_we", mem_we, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("mid_rst_sp", sp, 32'h0100);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_unf", underflow, 0);
    tick();
    check("mid_no_w3", mem_we, 0);
    check("mid_sp_hold", sp, 32'h0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sp_frame_unit.md
Name: sp_frame_unit

Overview:
Parametrised stack-pointer unit for a full-descending stack, replacing the single-step subtractor.
- Owns the SP register and handles single-word push/pop and multi-word call/return frames.
- Drives the data-memory address and read/write strobes for each stacked word.
- Bounds-checks every operation against a configurable stack window and keeps sticky error flags.

Parameters:
W, 16, width of SP and memory address
STEP, 1, address decrement/increment per stacked word (1..2^W-1)
FRAME, 2, words moved by call/ret (return address plus saved state), >=1
SP_TOP, 16'hFFFF, reset/empty SP value (highest address, exclusive bound)
SP_LIMIT, 16'h0000, lowest legal SP value (inclusive); SP_LIMIT < SP_TOP

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active low
push  in  1  push one word
pop  in  1  pop one word
call  in  1  push FRAME words
ret  in  1  pop FRAME words
err_clr  in  1  clear overflow/underflow
sp  out  W  current stack pointer (registered)
mem_addr  out  W  address of word being moved (registered)
mem_we  out  1  write strobe, one cycle per pushed word
mem_re  out  1  read strobe, one cycle per popped word
busy  out  1  frame transfer in progress; commands ignored
empty  out  1  sp == SP_TOP (combinational from sp)
full  out  1  sp < SP_LIMIT+STEP (combinational, W+1-bit compare)
overflow  out  1  sticky: push/call refused for lack of space
underflow  out  1  sticky: pop/ret refused, stack too shallow

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset, sampled at the edge, with priority over everything:
  - sp=SP_TOP, mem_addr=0, mem_we=0, mem_re=0, busy=0, overflow=0, underflow=0, state=IDLE.
  - Reset during CALL/RET aborts the frame; no further strobes.
- States:
  - IDLE: commands sampled on each edge.
  - CALL / RET: internal word counter 0..FRAME-1; busy=1.
- Command priority in IDLE: call > ret > push > pop.
  - push and pop in the same cycle with neither call nor ret is a no-op: no strobes, no flag change.
- Bounds checks use W+1-bit arithmetic so nothing wraps:
  - push legal iff sp >= SP_LIMIT+STEP
  - pop legal iff sp+STEP <= SP_TOP
  - call legal iff sp >= SP_LIMIT+FRAME*STEP
  - ret legal iff sp+FRAME*STEP <= SP_TOP
  - Illegal op: sp unchanged, no strobe, overflow (push/call) or underflow (pop/ret) set at that edge, state stays IDLE.
- push (legal), one cycle latency: after the edge, sp=sp-STEP, mem_addr=new sp, mem_we=1 for exactly one cycle.
- pop (legal), one cycle latency: after the edge, mem_addr=old sp, mem_re=1 for one cycle, sp=old sp+STEP.
- call (legal):
  - The accepting edge enters CALL; word 1 appears after that edge, per push semantics.
  - Words 2..FRAME follow on consecutive cycles.
  - busy=1 for exactly FRAME cycles; the edge after word FRAME returns to IDLE with busy=0 and mem_we=0.
  - Net sp change: -FRAME*STEP.
- ret (legal): mirror of call using pop semantics in state RET; net +FRAME*STEP; busy FRAME cycles.
- While busy: push/pop/call/ret ignored, not queued, no flag effect.
- Strobes: mem_we and mem_re are never high together; both 0 in IDLE except the single-word cycle.
- Sticky flags:
  - Cleared by err_clr at an edge.
  - If err_clr and a new error coincide, the flag stays set (set wins).
  - err_clr has no effect on sp/state.

Test Plan:
- Params W=16, STEP=2, FRAME=3, SP_TOP=16'h0100, SP_LIMIT=16'h00F0 (8-word capacity).
- Reset: rst_n=0 for 2 cycles -> sp=0x0100, empty=1, full=0, busy=0, all strobes/flags 0.
- Push/pop: push 1 cycle -> sp=0x00FE, mem_addr=0x00FE, mem_we=1 for one cycle; then pop -> mem_addr=0x00FE, mem_re=1, sp=0x0100, empty=1.
- Call/ret:
  - call from 0x0100 -> busy=1 for 3 cycles, mem_addr 0x00FE, 0x00FC, 0x00FA with mem_we=1 each cycle, final sp=0x00FA.
  - push held high during the call -> ignored, sp stays 0x00FA.
  - ret -> mem_addr 0x00FA, 0x00FC, 0x00FE with mem_re=1, sp=0x0100.
- Full/overflow:
  - 8 pushes -> sp=0x00F0, full=1.
  - 9th push -> sp stays 0x00F0, overflow=1, no mem_we.
  - Pop 2 words, then call (needs 6 bytes, has 4) -> refused, overflow stays 1.
  - err_clr -> overflow=0.
- Underflow/simultaneous:
  - At sp=0x0100, pop -> underflow=1, sp unchanged.
  - push+pop together at sp=0x00FC -> no strobes, sp=0x00FC.
  - ret at sp=0x00FC (needs 6, has 4) -> underflow=1.
- Reset mid-call: assert rst_n=0 after word 2 of a call from 0x0100 -> next cycle sp=0x0100, busy=0, mem_we=0, no third write.
